// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch next-PC select, stall gating and start/halt/step FSM.
// Optional single-step debug mode enabled by defining PC_SEQ_STEP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        HaltInstr,
    input  logic        DbgStep,
    input  logic        DbgStepMode,
    input  logic [31:0] PCResult,
    output logic [31:0] PC_In,
    output logic        PC_Enable,
    output logic        Halted,
    output logic        AlignErr,
    output logic [31:0] InstrCount,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q;
    logic        halted_q;
    logic        align_err_q;
    logic        step_pend_q;
    logic [31:0] count_q;
    logic [31:0] count_d;

    logic        step_req;
    logic        step_mode;
    logic        unblocked;
    logic        redirect;
    logic        misaligned;
    logic [31:0] raw_target;
    logic [31:0] next_addr;
    logic [31:0] pc_in;
    logic        pc_en;

`ifdef PC_SEQ_STEP_EN
    assign step_req  = DbgStep;
    assign step_mode = DbgStepMode;
`else
    logic unused_dbg;
    assign step_req   = 1'b0;
    assign step_mode  = 1'b0;
    assign unused_dbg = &{1'b0, DbgStep, DbgStepMode};
`endif

    always_comb begin
        unblocked  = !Stall || BranchTaken;
        redirect   = BranchTaken || Jump;
        raw_target = BranchTaken ? BranchTarget : JumpTarget;
        misaligned = redirect && (raw_target[1:0] != 2'b00);
        next_addr  = redirect ? {raw_target[31:2], 2'b00} : PCResult + 32'd4;
        count_d    = count_q + 32'd1;
        pc_in      = PCResult;
        pc_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_in = RESET_PC;
                pc_en = 1'b1;
            end
            RUN: begin
                pc_in = next_addr;
                pc_en = unblocked;
            end
            STEP: begin
                // A step that arrived during a stall stays pending until it can land.
                pc_in = next_addr;
                pc_en = (step_req || step_pend_q) && unblocked;
            end
            HALTED: begin
                pc_in = PCResult;
                pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            halted_q    <= 1'b0;
            align_err_q <= 1'b0;
            step_pend_q <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_q     <= 32'd0;
                    step_pend_q <= 1'b0;
                    if (Start) state_q <= step_mode ? STEP : RUN;
                end
                RUN, STEP: begin
                    if (pc_en) count_q <= count_d;
                    if (pc_en && misaligned) align_err_q <= 1'b1;
                    if (state_q == STEP) begin
                        if (pc_en)         step_pend_q <= 1'b0;
                        else if (step_req) step_pend_q <= 1'b1;
                    end
                    if (pc_en && HaltInstr) begin
                        state_q     <= HALTED;
                        halted_q    <= 1'b1;
                        step_pend_q <= 1'b0;
                    end else if (state_q == RUN && step_mode) begin
                        state_q <= STEP;
                    end else if (state_q == STEP && !step_mode) begin
                        state_q     <= RUN;
                        step_pend_q <= 1'b0;
                    end
                end
                HALTED: begin
                    if (Start) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                        count_q  <= 32'd0;
                    end
                end
            endcase
        end
    end

    assign PC_In      = pc_in;
    assign PC_Enable  = pc_en;
    assign Halted     = halted_q;
    assign AlignErr   = align_err_q;
    assign InstrCount = count_q;
    assign State      = state_q;

endmodule
